pipe_stage_reg: RTL

Parametrised pipeline stage register, successor to the fixed IF/ID latch. It carries a DATA_W-bit payload (e.g. {PC, PC+4, instruction}) between any two stages with a valid/ready handshake, synchronous flush with bubble insertion, and a saturating stall counter. An optional skid slot registers the upstream ready path. It sits between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_skid_slot.sv | 57 +++++
 rtl/pipe_stage_reg.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared pipeline definitions. This package holds the standard
//            payload widths, the bubble instruction encoding and the packed
//            payload layouts that travel through pipe_stage_reg instances.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // An all-zero word decodes as sll $0,$0,0, so this is a harmless bubble.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID payload: {PC, PC+4, instruction}. This layout is 96 bits wide.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  // ID/EX payload: operands and control fields after decode.
  typedef struct packed {
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic [31:0]       imm;
    logic [4:0]        rd;
  } id_ex_t;

  localparam int IF_ID_W = $bits(if_id_t);
  localparam int ID_EX_W = $bits(id_ex_t);

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_slot
// Purpose  : A one-entry holding register with a valid bit. The parent stage
//            uses it to park a beat that arrives while its main register is
//            full and stalled.
// Ports    : clk      - stage clock. The active edge is set by CLK_NEGEDGE.
//            reset    - asynchronous, active-low reset.
//            i_load   - capture i_data and mark the slot occupied.
//            i_unload - the beat was handed to the main register; free slot.
//            i_clear  - flush. It empties the slot and takes priority.
//            i_data   - beat to capture.
//            o_valid  - slot occupied.
//            o_data   - held beat.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 96,
  parameter int CLK_NEGEDGE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              w_clk_act;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  assign w_clk_act = (CLK_NEGEDGE != 0) ? ~clk : clk;

  always_ff @(posedge w_clk_act or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : A parametrised pipeline stage register with a valid/ready
//            handshake. It supports synchronous flush with bubble insertion
//            and has a saturating stall counter.
// Config   : PIPE_STAGE_SKID_EN - when defined, a one-entry skid slot is
//            added. With the skid, in_ready comes from a register and up to
//            two beats are buffered. Without it, in_ready is combinational:
//            out_ready | ~out_valid.
// Ports    : clk       - stage clock. Capture happens on the falling edge if
//                        CLK_NEGEDGE=1, and on the rising edge otherwise.
//            reset     - asynchronous, active-low reset.
//            flush     - synchronous kill. It drives a NOP_VALUE bubble.
//            in_valid  - upstream beat present.
//            in_ready  - stage can accept.
//            in_data   - upstream payload [DATA_W].
//            out_valid - stage holds a valid beat.
//            out_ready - downstream accepts.
//            out_data  - registered payload [DATA_W].
//            stall_cnt - count of edges with out_valid=1 and out_ready=0.
//                        It saturates at its maximum value.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 96,
  parameter logic [DATA_W-1:0] NOP_VALUE   = '0,
  parameter int                CLK_NEGEDGE = 1,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   w_clk_act;
  logic                   r_out_valid;
  logic [DATA_W-1:0]      r_out_data;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_accept;
  logic                   w_release;
  logic                   w_load_main;
  logic                   w_skid_valid;
  logic [DATA_W-1:0]      w_skid_data;

  // All state in the stage shares one active edge.
  assign w_clk_act = (CLK_NEGEDGE != 0) ? ~clk : clk;

  assign w_release   = r_out_valid & out_ready;
  assign w_load_main = w_release | ~r_out_valid;
  assign w_accept    = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic w_skid_load;

  // The skid is occupied only while the main register is full. A flopped
  // ready is therefore enough, and out_ready has no path to in_ready.
  assign in_ready    = ~w_skid_valid;
  assign w_skid_load = w_accept & ~w_load_main & ~flush;

  pipe_skid_slot #(
    .DATA_W      (DATA_W),
    .CLK_NEGEDGE (CLK_NEGEDGE)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_load_main),
    .i_clear  (flush),
    .i_data   (in_data),
    .o_valid  (w_skid_valid),
    .o_data   (w_skid_data)
  );
`else
  assign in_ready     = out_ready | ~r_out_valid;
  assign w_skid_valid = 1'b0;
  assign w_skid_data  = '0;
`endif

  // Main register. A beat parked in the skid is older than any new beat, so
  // it is loaded first. When no beat arrives, the data field keeps its value.
  always_ff @(posedge w_clk_act or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= NOP_VALUE;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= NOP_VALUE;
    end else if (w_load_main) begin
      if (w_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_skid_data;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= in_data;
        end
      end
    end
  end

  // The stall counter ignores flush, so it can only be cleared by reset.
  always_ff @(posedge w_clk_act or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign stall_cnt = r_stall_cnt;

  // The upstream stage must hold its payload steady while it is back-pressured.
  property p_hold_payload;
    @(posedge w_clk_act) disable iff (!reset)
      (in_valid && !in_ready && !flush) |=> (in_data == $past(in_data));
  endproperty
  a_hold_payload: assert property (p_hold_payload);

endmodule
`default_nettype wire
